// File: rtl/axil_addr_map_responder.sv
// AXI4-Lite slave responder for the bench address map.
// A contiguous run of NUM_WINDOWS windows, each 2^WIN_BITS bytes, starts at
// BASE_ADDR. Each window holds REGS_PER_WIN 32-bit scratch registers.
// Addresses outside the windows get DECERR. Offsets past the register bank
// get SLVERR.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   s_axi_aw*/w*/b*     write address, write data and write response channels
//   s_axi_ar*/r*        read address and read data channels
//   decerr_count        saturating count of DECERR responses (reads + writes)
module axil_addr_map_responder #(
  parameter logic [63:0] BASE_ADDR    = 64'h0000020201000000,
  parameter int          NUM_WINDOWS  = 12,
  parameter int          WIN_BITS     = 16,
  parameter int          REGS_PER_WIN = 4,
  parameter logic [31:0] RESET_VALUE  = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [63:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [15:0] decerr_count
);

  localparam int unsigned NREGS = NUM_WINDOWS * REGS_PER_WIN;
  localparam int unsigned IDXW  = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_RESP} rstate_e;

  // Address decode. The addr < BASE_ADDR test guards the wrapped subtraction.
  function automatic logic [1:0] dec_resp(input logic [63:0] a);
    logic [63:0] win;
    win = (a - BASE_ADDR) >> WIN_BITS;
    if ((a < BASE_ADDR) || (win >= 64'(NUM_WINDOWS)))
      dec_resp = RESP_DECERR;
    else if (64'(a[WIN_BITS-1:0]) >= 64'(4 * REGS_PER_WIN))
      dec_resp = RESP_SLVERR;
    else
      dec_resp = RESP_OKAY;
  endfunction

  // Flat register index. It is forced to 0 for non-OKAY addresses so the
  // bank is never indexed out of range.
  function automatic logic [IDXW-1:0] dec_idx(input logic [63:0] a);
    logic [63:0] flat;
    flat = (((a - BASE_ADDR) >> WIN_BITS) * 64'(REGS_PER_WIN)) + 64'(a[WIN_BITS-1:2]);
    dec_idx = (dec_resp(a) == RESP_OKAY) ? IDXW'(flat) : '0;
  endfunction

  logic [31:0] regs_q [NREGS];

  // ---------------- write channel ----------------
  wstate_e     wstate_q, wstate_d;
  logic [63:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d;

  logic        aw_hs, w_hs;
  logic        commit;
  logic [63:0] c_addr;
  logic [31:0] c_data;
  logic [3:0]  c_strb;
  logic [1:0]  c_resp;
  logic [IDXW-1:0] c_idx;

  assign s_axi_awready = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_D);
  assign s_axi_wready  = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_A);
  assign s_axi_bvalid  = (wstate_q == W_RESP);
  assign s_axi_bresp   = bresp_q;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;

  always_comb begin
    wstate_d = wstate_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bresp_d  = bresp_q;
    commit   = 1'b0;
    c_addr   = s_axi_awaddr;
    c_data   = s_axi_wdata;
    c_strb   = s_axi_wstrb;
    unique case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit   = 1'b1;
          wstate_d = W_RESP;
        end else if (aw_hs) begin
          awaddr_d = s_axi_awaddr;
          wstate_d = W_HAVE_A;
        end else if (w_hs) begin
          wdata_d  = s_axi_wdata;
          wstrb_d  = s_axi_wstrb;
          wstate_d = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        c_addr = awaddr_q;
        if (w_hs) begin
          commit   = 1'b1;
          wstate_d = W_RESP;
        end
      end
      W_HAVE_D: begin
        c_data = wdata_q;
        c_strb = wstrb_q;
        if (aw_hs) begin
          commit   = 1'b1;
          wstate_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_bready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
    if (commit) bresp_d = dec_resp(c_addr);
  end

  assign c_resp = dec_resp(c_addr);
  assign c_idx  = dec_idx(c_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q <= W_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= '0;
    end else begin
      wstate_q <= wstate_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
    end
  end

  // Register bank. A read on the same edge samples the pre-write value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= RESET_VALUE;
    end else if (commit && (c_resp == RESP_OKAY)) begin
      for (int unsigned b = 0; b < 4; b++)
        if (c_strb[b]) regs_q[c_idx][8*b +: 8] <= c_data[8*b +: 8];
    end
  end

  // ---------------- read channel ----------------
  rstate_e     rstate_q, rstate_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        ar_hs;
  logic [1:0]  ar_resp;
  logic [IDXW-1:0] ar_idx;

  assign s_axi_arready = (rstate_q == R_IDLE);
  assign s_axi_rvalid  = (rstate_q == R_RESP);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign ar_resp = dec_resp(s_axi_araddr);
  assign ar_idx  = dec_idx(s_axi_araddr);

  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    unique case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rresp_d  = ar_resp;
          rdata_d  = (ar_resp == RESP_OKAY) ? regs_q[ar_idx] : '0;
          rstate_d = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axi_rready) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= '0;
    end else begin
      rstate_q <= rstate_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  // ---------------- DECERR counter ----------------
  logic [15:0] decerr_q, decerr_d;
  logic [1:0]  dec_inc;
  logic [16:0] dec_sum;

  always_comb begin
    dec_inc  = {1'b0, commit && (c_resp == RESP_DECERR)}
             + {1'b0, ar_hs && (ar_resp == RESP_DECERR)};
    dec_sum  = {1'b0, decerr_q} + 17'(dec_inc);
    decerr_d = dec_sum[16] ? '1 : dec_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) decerr_q <= '0;
    else     decerr_q <= decerr_d;
  end

  assign decerr_count = decerr_q;

endmodule

// File: doc/axil_addr_map_responder.md
Name: axil_addr_map_responder

Overview:
- AXI4-Lite slave responder for the testbench address map: the target end of the transactions the bench master issues.
- Decodes 64-bit addresses against a contiguous block of 64 KB windows starting at BASE_ADDR.
- Each window holds a small scratch register bank; unmapped windows return DECERR, unmapped offsets return SLVERR.
- Sits behind the bench interconnect in place of the APB/AXI peripheral windows (DCM, PNS, HSM, REG, I3C0-7).

Parameters:
- BASE_ADDR, 64'h0000020201000000, address of window 0; aligned to 2^WIN_BITS.
- NUM_WINDOWS, 12, number of mapped windows (1..16).
- WIN_BITS, 16, log2 of window size (0x10000).
- REGS_PER_WIN, 4, 32-bit registers per window at offsets 0x0, 0x4, ...
- RESET_VALUE, 32'h00000000, reset value of every register.

Ports:
- clk  in  1  clock (only clock).
- rst  in  1  reset, asynchronous, active-high.
- s_axi_awaddr  in  64  write address.
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte strobes.
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake.
- s_axi_araddr  in  64  read address.
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake.
- decerr_count  out  16  saturating count of DECERR responses (reads plus writes).

Behaviour:
- Reset (asynchronous, rst=1):
  - all registers = RESET_VALUE; decerr_count=0.
  - bvalid=rvalid=0; bresp=rresp=rdata=0.
  - awready=wready=arready=1.
  - Both FSMs return to IDLE. Any in-flight transaction is dropped; no response is issued for it.
- Decode:
  - idx = (addr - BASE_ADDR) >> WIN_BITS.
  - Hit if addr >= BASE_ADDR and idx < NUM_WINDOWS.
  - Miss -> DECERR (2'b11).
  - Hit with offset addr[WIN_BITS-1:0] >= 4*REGS_PER_WIN -> SLVERR (2'b10).
  - Otherwise OKAY (2'b00); register = addr[WIN_BITS-1:2].
  - addr[1:0] is ignored.
- Write FSM states: W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP.
  - awready=1 in W_IDLE and W_HAVE_D. wready=1 in W_IDLE and W_HAVE_A. bvalid=1 only in W_RESP.
  - W_IDLE, AW and W handshake on the same edge: commit on that edge -> W_RESP.
  - W_IDLE, AW only: latch address -> W_HAVE_A. W only: latch data and strobe -> W_HAVE_D.
  - W_HAVE_A + W handshake, or W_HAVE_D + AW handshake: commit -> W_RESP.
  - W_RESP: bresp held stable while bready=0; bvalid & bready -> W_IDLE.
  - One outstanding write at a time.
- Commit rules:
  - OKAY: byte i is written iff wstrb[i]. wstrb=0 writes nothing and still returns OKAY.
  - SLVERR or DECERR: no register changes.
- Read FSM states: R_IDLE, R_RESP.
  - arready=1 only in R_IDLE.
  - AR handshake -> rdata/rresp registered on that edge -> R_RESP with rvalid=1 (1-cycle latency).
  - rdata = register value for OKAY, 0 for errors.
  - rvalid & rready -> R_IDLE. No back-to-back reads; arready returns 1 one cycle after the R handshake.
- Simultaneous events:
  - Read and write commit to the same register on the same edge: read returns the pre-write value.
  - Both channels producing a DECERR on the same edge: decerr_count += 2.
  - decerr_count saturates at 16'hFFFF; it never wraps.
- Read and write FSMs are fully independent; neither blocks the other.

Test Plan:
- Write 0xDEADBEEF, wstrb 0xF, to 0x0000020201030004 with AW and W on the same cycle -> bvalid one cycle later with bresp=00; read back gives rdata=0xDEADBEEF, rresp=00, one cycle after the AR handshake.
- Then write 0x12345678, wstrb 0x3, to the same address -> read returns 0xDEAD5678.
- W issued 3 cycles before AW (0x0000020201000000, 0xA5A5A5A5) -> wready=0 while waiting, awready=1; response issued after AW; read returns 0xA5A5A5A5. Hold bready=0 for 5 cycles -> bvalid stays 1, bresp stable, awready=wready=0.
- Read 0x00000202010C0000 (window 12) and write 0x0000020000000000 -> rresp=11, rdata=0, bresp=11; decerr_count=2; no register changes.
- Write 0xFFFFFFFF to 0x0000020201000010 (offset 0x10) -> bresp=10; read of 0x0000020201000000 still returns its prior value.
- Assert rst in W_HAVE_A and again while rvalid=1 -> bvalid=rvalid=0 and all ready outputs=1 immediately; all registers read back 0x00000000; decerr_count=0.
